// File: rtl/p4_op_sequencer.sv
// p4_op_sequencer: operand sequencer wrapped around an external combinational
// P4 adder. Operand pairs are buffered in a 4-entry FIFO, issued one at a time
// onto a_o/b_o/cin_o, and the adder result (scomb_i/cout_i) is captured into a
// valid/ready output register together with a signed-overflow flag.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid/in_ready     upstream handshake for {in_a, in_b, in_cin}
//   a_o, b_o, cin_o       operands driven to the adder
//   scomb_i, cout_i       adder sum and carry-out
//   out_valid/out_ready   downstream handshake for {out_sum, out_cout, out_ovf}
//   done_cnt              wrapping count of completed output handshakes
module p4_op_sequencer #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_a,
    input  logic [DWIDTH-1:0] in_b,
    input  logic              in_cin,
    output logic [DWIDTH-1:0] a_o,
    output logic [DWIDTH-1:0] b_o,
    output logic              cin_o,
    input  logic [DWIDTH-1:0] scomb_i,
    input  logic              cout_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_sum,
    output logic              out_cout,
    output logic              out_ovf,
    output logic [15:0]       done_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned MSB   = DWIDTH - 1;

    // FIFO storage (no reset needed: occupancy is tracked by cnt_q)
    logic [DWIDTH-1:0] fa_q [DEPTH];
    logic [DWIDTH-1:0] fb_q [DEPTH];
    logic              fc_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drv_vld_q, drv_vld_d;
    logic [DWIDTH-1:0] a_q, a_d;
    logic [DWIDTH-1:0] b_q, b_d;
    logic              cin_q, cin_d;
    logic              ov_q, ov_d;
    logic [DWIDTH-1:0] sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       done_q, done_d;

    logic push;
    logic pop;
    logic res_free;
    logic capture;
    logic handshake;

    // Ready depends only on registered occupancy, so a full FIFO never
    // accepts even when it is popped in the same cycle.
    assign in_ready  = (cnt_q < CNT_W'(DEPTH));
    assign push      = in_valid & in_ready;
    assign res_free  = ~ov_q | out_ready;
    assign capture   = drv_vld_q & res_free;
    assign pop       = (cnt_q != '0) & (~drv_vld_q | capture);
    assign handshake = ov_q & out_ready;

    // Next-state logic for pointers, issue stage, result stage and counter
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        drv_vld_d = drv_vld_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        ov_d      = ov_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        done_d    = done_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Issue: head of FIFO onto the adder inputs; otherwise hold them
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            a_d       = fa_q[rd_ptr_q];
            b_d       = fb_q[rd_ptr_q];
            cin_d     = fc_q[rd_ptr_q];
            drv_vld_d = 1'b1;
        end else if (capture) begin
            drv_vld_d = 1'b0;
        end

        // Capture: overflow judged from the operands actually on the adder
        if (capture) begin
            sum_d  = scomb_i;
            cout_d = cout_i;
            ovf_d  = (a_q[MSB] == b_q[MSB]) & (scomb_i[MSB] != a_q[MSB]);
            ov_d   = 1'b1;
        end else if (out_ready) begin
            ov_d   = 1'b0;
        end

        if (handshake) begin
            done_d = done_q + 16'(1);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            drv_vld_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            ov_q      <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            drv_vld_q <= drv_vld_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            ov_q      <= ov_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    // FIFO write port
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fa_q[wr_ptr_q] <= in_a;
            fb_q[wr_ptr_q] <= in_b;
            fc_q[wr_ptr_q] <= in_cin;
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign cin_o     = cin_q;
    assign out_valid = ov_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign done_cnt  = done_q;

endmodule

// File: tb/tb_p4_op_sequencer.sv
// tb_p4_op_sequencer: drives p4_op_sequencer with directed and random operand
// streams, models the external adder combinationally, and checks every
// result against an arithmetic reference kept in an in-order scoreboard.
module tb_p4_op_sequencer;

    localparam int unsigned DW  = 32;
    localparam int unsigned DW1 = DW + 1;

    typedef struct packed {
        logic [DW-1:0] sum;
        logic          cout;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_cin;
    logic [DW-1:0] a_o;
    logic [DW-1:0] b_o;
    logic          cin_o;
    logic [DW-1:0] scomb;
    logic          cout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic [15:0]   done_cnt;
    logic [DW:0]   add_w;

    always #5 clk = ~clk;

    // Combinational adder standing in for the P4 adder
    assign add_w = {1'b0, a_o} + {1'b0, b_o} + DW1'(cin_o);
    assign scomb = add_w[DW-1:0];
    assign cout  = add_w[DW];

    p4_op_sequencer #(.DWIDTH(DW), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .a_o(a_o), .b_o(b_o), .cin_o(cin_o),
        .scomb_i(scomb), .cout_i(cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .done_cnt(done_cnt)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    logic [15:0] model_done = '0;
    exp_t        exp_q[$];
    int          hs_log[$];
    logic        rec = 1'b0;
    logic        last_acc;
    logic        last_hs;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: true sum, carry and signed overflow from plain arithmetic
    function automatic exp_t ref_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c);
        exp_t            e;
        longint unsigned u;
        longint          s;
        u = 64'(a) + 64'(b) + 64'(c);
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        e.sum  = u[DW-1:0];
        e.cout = u[DW];
        e.ovf  = (s > 2147483647) || (s < -2147483647 - 1);
        return e;
    endfunction

    // One clock: drive at negedge, resolve handshakes, return just past posedge
    task automatic cycle(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic c, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = c;
        out_ready = ordy;
        #1;
        last_acc = in_valid & in_ready & rst_n;
        last_hs  = out_valid & out_ready & rst_n;
        if (rst_n) check_val("done_cnt", 64'(done_cnt), 64'(model_done));
        if (last_hs) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_result", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_val("out_sum", 64'(out_sum), 64'(e.sum));
                check_val("out_cout", 64'(out_cout), 64'(e.cout));
                check_val("out_ovf", 64'(out_ovf), 64'(e.ovf));
            end
            model_done = model_done + 16'(1);
            if (rec) hs_log.push_back(cyc);
        end
        if (last_acc) exp_q.push_back(ref_op(a, b, c));
        if (!rst_n) begin
            exp_q.delete();
            model_done = '0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < bound) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
            n++;
        end
        check_val("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [DW-1:0] a8 [8];
        logic [DW-1:0] b8 [8];
        logic          c8 [8];
        logic [DW-1:0] ra, rb, saved_a, saved_b;
        logic          rc, rv;
        logic [15:0]   base;
        int            idx, hs_n, guard;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_a_o", 64'(a_o), 64'(0));
        check_val("rst_done", 64'(done_cnt), 64'(0));
        rst_n = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check_val("ready_after_rst", 64'(in_ready), 64'(1));

        // Single op latency: accept E0, issue E0+1, result E0+2
        cycle(1'b1, 32'd5, 32'd7, 1'b1, 1'b1);
        check_val("lat_accept", 64'(last_acc), 64'(1));
        check_val("lat_e0_valid", 64'(out_valid), 64'(0));
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check_val("lat_e1_a_o", 64'(a_o), 64'(5));
        check_val("lat_e1_valid", 64'(out_valid), 64'(0));
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check_val("lat_e2_valid", 64'(out_valid), 64'(1));
        check_val("lat_e2_sum", 64'(out_sum), 64'(13));
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check_val("lat_done1", 64'(done_cnt), 64'(1));

        // Carry and overflow corners
        cycle(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        cycle(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        drain(20);

        // Backpressure: only six ops fit while out_ready is low
        for (int i = 0; i < 8; i++) begin
            a8[i] = $urandom; b8[i] = $urandom; c8[i] = 1'($urandom);
        end
        idx = 0; saved_a = '0; saved_b = '0;
        for (int i = 0; i < 12; i++) begin
            cycle(idx < 8, a8[idx % 8], b8[idx % 8], c8[idx % 8], 1'b0);
            if (last_acc) idx++;
            if (i == 4) begin saved_a = a_o; saved_b = b_o; end
        end
        check_val("bp_accepted", 64'(idx), 64'(6));
        check_val("bp_in_ready", 64'(in_ready), 64'(0));
        check_val("bp_a_stable", 64'(a_o), 64'(saved_a));
        check_val("bp_b_stable", 64'(b_o), 64'(saved_b));
        hs_n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(idx < 8, a8[idx % 8], b8[idx % 8], c8[idx % 8], 1'b1);
            if (last_acc) idx++;
            if (last_hs) hs_n++;
        end
        check_val("bp_six_results", 64'(hs_n), 64'(6));
        guard = 0;
        while (idx < 8 && guard < 20) begin
            cycle(1'b1, a8[idx], b8[idx], c8[idx], 1'b1);
            if (last_acc) idx++;
            guard++;
        end
        check_val("bp_rest_accepted", 64'(idx), 64'(8));
        drain(20);

        // Full-rate stream of 10 ops
        base = model_done; idx = 0; guard = 0;
        hs_log.delete(); rec = 1'b1;
        while (idx < 10 && guard < 40) begin
            cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'b1);
            if (last_acc) idx++;
            guard++;
        end
        drain(20);
        rec = 1'b0;
        check_val("stream_n", 64'(hs_log.size()), 64'(10));
        if (hs_log.size() == 10)
            check_val("stream_back2back", 64'(hs_log[9] - hs_log[0]), 64'(9));
        check_val("stream_done", 64'(done_cnt - base), 64'(10));

        // Random valid/ready traffic
        rv = 1'b0; ra = '0; rb = '0; rc = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!rv || last_acc) begin
                rv = 1'($urandom_range(0, 1)); ra = $urandom; rb = $urandom; rc = 1'($urandom);
                if ((i % 7) == 0) begin ra = 32'h8000_0000; rb = 32'h8000_0000; end
            end
            cycle(rv, ra, rb, rc, 1'($urandom_range(0, 3) != 0));
        end
        drain(20);

        // Reset with ops in flight: 3 queued, 1 driven, 1 result pending
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        check_val("pre_rst_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1);
        rst_n = 1'b1;
        check_val("inflight_rst_valid", 64'(out_valid), 64'(0));
        check_val("inflight_rst_ready", 64'(in_ready), 64'(1));
        check_val("inflight_rst_done", 64'(done_cnt), 64'(0));
        hs_n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
            if (out_valid) hs_n++;
        end
        check_val("no_stale_result", 64'(hs_n), 64'(0));

        // done_cnt wrap after 65535 handshakes
        guard = 0;
        while (model_done != 16'hFFFF && guard < 70000) begin
            cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'b1);
            guard++;
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check_val("done_ffff", 64'(done_cnt), 64'(16'hFFFF));
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check_val("done_wrap", 64'(done_cnt), 64'(0));
        drain(20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
